// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run controller: state encoding and counter width helper.
package cpu_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HOLD = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    HOLD = ST_HOLD,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // Bits needed to hold 0..n; never less than 1 so n=0 still yields a legal vector.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cpu_run_controller_stability.sv
// Counts consecutive cycles where data_result equals the expected value, saturating at
// STABLE_CYCLES; a mismatch restarts the count.
module result_stability_counter
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data_result,
  input  logic [DATA_WIDTH-1:0] expected,
  output logic                  hit
);

  localparam int SW = cnt_w(STABLE_CYCLES);
  localparam logic [SW-1:0] SMAX = SW'(STABLE_CYCLES);

  logic [SW-1:0] cnt_q, cnt_d, cnt_step;
  logic          match;

  always_comb begin
    match    = (data_result == expected);
    cnt_step = '0;
    if (match) cnt_step = (cnt_q == SMAX) ? cnt_q : cnt_q + SW'(1);
    cnt_d = cnt_q;
    if (clear)   cnt_d = '0;
    else if (en) cnt_d = cnt_step;
    // Raised on the cycle whose sample completes the window, so the caller can leave RUN now.
    hit = en && (cnt_step == SMAX);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller for the single-cycle CPU: sequences CPU reset, counts run cycles and
// reports pass once data_result settles on the expected value, or timeout.
module cpu_run_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int RESET_CYCLES  = 2,
  parameter int MAX_CYCLES    = 1024,
  parameter int STABLE_CYCLES = 4,
  parameter int RERESET_COUNT = 0,
  parameter int RERESET_AT    = 5,
  localparam int CNT_W        = cnt_w(MAX_CYCLES)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] expected_result,
  input  logic [DATA_WIDTH-1:0] data_result,
  output logic                  cpu_reset,
  output logic [CNT_W-1:0]      cycle_count,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout
);

  localparam int HW = cnt_w(RESET_CYCLES);
  localparam int RW = cnt_w(RERESET_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] RR_AT     = CNT_W'(RERESET_AT);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [RW-1:0]    RR_MAX    = RW'(RERESET_COUNT);
  localparam bit               RR_EN     = (RERESET_COUNT > 0);

  state_e                  state_q, state_d;
  logic [HW-1:0]           hold_q, hold_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [RW-1:0]           rr_q, rr_d;
  logic [DATA_WIDTH-1:0]   exp_q, exp_d;
  logic                    cpu_reset_q, cpu_reset_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic                    timeout_q, timeout_d;
  logic                    start_ok, rr_fire, stab_en, stab_clear, stab_hit, go_pass;

  assign start_ok   = start && (state_q == IDLE || state_q == DONE);
  assign rr_fire    = RR_EN && (state_q == RUN) && (cnt_q == RR_AT) && (rr_q < RR_MAX);
  assign stab_en    = (state_q == RUN);
  assign stab_clear = start_ok || rr_fire;

  result_stability_counter #(
    .DATA_WIDTH   (DATA_WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_stab (
    .clock      (clock),
    .reset      (reset),
    .clear      (stab_clear),
    .en         (stab_en),
    .data_result(data_result),
    .expected   (exp_q),
    .hit        (stab_hit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      cnt_q       <= '0;
      rr_q        <= '0;
      exp_q       <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      exp_q       <= exp_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    exp_d   = exp_q;
    go_pass = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = HOLD;
          exp_d   = expected_result;
          hold_d  = '0;
          cnt_d   = '0;
          rr_d    = '0;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      RUN: begin
        // Re-reset outranks pass, which outranks timeout.
        if (rr_fire) begin
          state_d = HOLD;
          cnt_d   = '0;
          hold_d  = '0;
          rr_d    = rr_q + RW'(1);
        end else if (stab_hit) begin
          state_d = DONE;
          go_pass = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_reset_d = (state_d != RUN);
    done_d      = (state_d == DONE);
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    if (state_d != DONE) begin
      pass_d    = 1'b0;
      timeout_d = 1'b0;
    end else if (state_q == RUN) begin
      pass_d    = go_pass;
      timeout_d = !go_pass;
    end
  end

  assign cpu_reset   = cpu_reset_q;
  assign cycle_count = cnt_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: four parameterisations share clock/reset/start.
module tb_cpu_run_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] expected_result = '0;
  logic [31:0] d_def = '0, d_to = '0, d_rr = '0, d_ct = 32'h7;

  logic        cr_def, dn_def, ps_def, to_def;
  logic [10:0] cc_def;
  logic        cr_to, dn_to, ps_to, to_to;
  logic [4:0]  cc_to;
  logic        cr_rr, dn_rr, ps_rr, to_rr;
  logic [10:0] cc_rr;
  logic        cr_ct, dn_ct, ps_ct, to_ct;
  logic [2:0]  cc_ct;

  int errs = 0;
  int checks = 0;

  always #50 clock = ~clock;

  cpu_run_controller u_def (
    .clock(clock), .reset(reset), .start(start), .expected_result(expected_result),
    .data_result(d_def), .cpu_reset(cr_def), .cycle_count(cc_def), .done(dn_def),
    .pass(ps_def), .timeout(to_def));

  cpu_run_controller #(.MAX_CYCLES(16)) u_to (
    .clock(clock), .reset(reset), .start(start), .expected_result(expected_result),
    .data_result(d_to), .cpu_reset(cr_to), .cycle_count(cc_to), .done(dn_to),
    .pass(ps_to), .timeout(to_to));

  cpu_run_controller #(.RERESET_COUNT(2), .RERESET_AT(5)) u_rr (
    .clock(clock), .reset(reset), .start(start), .expected_result(expected_result),
    .data_result(d_rr), .cpu_reset(cr_rr), .cycle_count(cc_rr), .done(dn_rr),
    .pass(ps_rr), .timeout(to_rr));

  cpu_run_controller #(.MAX_CYCLES(4), .STABLE_CYCLES(4)) u_ct (
    .clock(clock), .reset(reset), .start(start), .expected_result(expected_result),
    .data_result(d_ct), .cpu_reset(cr_ct), .cycle_count(cc_ct), .done(dn_ct),
    .pass(ps_ct), .timeout(to_ct));

  typedef struct {
    logic        st;
    logic [31:0] exp_in;
    logic [31:0] dat;
    logic        cr;
    logic [31:0] cc;
    logic        dn;
    logic        ps;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Pass run on defaults: start at edge 0, two HOLD edges, data=7 sampled from run cycle 10.
    for (int i = 0; i < 18; i++) begin
      tbl[i].st     = (i == 0);
      tbl[i].exp_in = (i == 0) ? 32'h7 : 32'h1234;
      tbl[i].dat    = (i >= 13) ? 32'h7 : 32'h0;
      tbl[i].cr     = !(i >= 2 && i <= 15);
      tbl[i].cc     = (i < 2) ? 0 : (i <= 15) ? 32'(i - 2) : 32'd13;
      tbl[i].dn     = (i >= 16);
      tbl[i].ps     = (i >= 16);
    end

    // Reset state and quiescence until start.
    step();
    step();
    chk("rst_cpu_reset", 32'(cr_def), 1);
    chk("rst_done", 32'(dn_def), 0);
    chk("rst_count", 32'(cc_def), 0);
    chk("rst_pass_timeout", {30'b0, ps_def, to_def}, 0);
    reset = 1'b0;
    step(); step(); step();
    chk("idle_cpu_reset", 32'(cr_def), 1);
    chk("idle_done_count", {20'b0, dn_def, cc_def}, 0);

    // Table-driven pass run.
    for (int i = 0; i < 18; i++) begin
      start           = tbl[i].st;
      expected_result = tbl[i].exp_in;
      d_def           = tbl[i].dat;
      step();
      chk($sformatf("pass_v%0d_cpu_reset", i), 32'(cr_def), 32'(tbl[i].cr));
      chk($sformatf("pass_v%0d_count", i), 32'(cc_def), tbl[i].cc);
      chk($sformatf("pass_v%0d_done", i), 32'(dn_def), 32'(tbl[i].dn));
      chk($sformatf("pass_v%0d_pass", i), 32'(ps_def), 32'(tbl[i].ps));
    end
    start = 1'b0;
    chk("pass_timeout_low", 32'(to_def), 0);

    // Flicker, restarted straight from DONE: 3 matches, 1 mismatch, 4 matches.
    start = 1'b1;
    expected_result = 32'h7;
    d_def = 32'h5;
    step();
    start = 1'b0;
    chk("flk_restart_flags", {29'b0, cr_def, dn_def, ps_def}, 32'b100);
    step();
    step();
    chk("flk_run_c0", {20'b0, cr_def, cc_def}, 0);
    for (int c = 0; c < 8; c++) begin
      d_def = (c == 3) ? 32'h5 : 32'h7;
      step();
      if (c == 6) chk("flk_no_early_pass", 32'(dn_def), 0);
    end
    chk("flk_done_pass", {30'b0, dn_def, ps_def}, 32'b11);
    chk("flk_count", 32'(cc_def), 7);

    // Timeout (MAX 16) and pass/timeout contention (MAX 4, STABLE 4) from one start.
    do_reset();
    d_to = 32'h0;
    d_ct = 32'h7;
    start = 1'b1;
    expected_result = 32'h7;
    step();
    start = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (k == 5) chk("ct_before", {28'b0, dn_ct, cc_ct}, 3);
      if (k == 6) begin
        chk("ct_pass_wins", {29'b0, dn_ct, ps_ct, to_ct}, 32'b110);
        chk("ct_count", 32'(cc_ct), 3);
      end
      if (k == 17) chk("to_before", {26'b0, dn_to, cc_to}, 15);
      if (k == 18) begin
        chk("to_flags", {28'b0, cr_to, dn_to, ps_to, to_to}, 32'b1101);
        chk("to_count", 32'(cc_to), 15);
      end
    end

    // Re-reset mode: two re-resets at run cycle 5, third run passes.
    do_reset();
    d_rr = 32'h0;
    start = 1'b1;
    expected_result = 32'h7;
    step();
    start = 1'b0;
    chk("rr_k0_cpu_reset", 32'(cr_rr), 1);
    for (int k = 1; k <= 22; k++) begin
      logic want_cr;
      if (k == 18) d_rr = 32'h7;
      step();
      want_cr = (k <= 1) || (k == 8) || (k == 9) || (k == 16) || (k == 17) || (k >= 22);
      chk($sformatf("rr_k%0d_cpu_reset", k), 32'(cr_rr), 32'(want_cr));
      if (k == 7)  chk("rr_c5_count", 32'(cc_rr), 5);
      if (k == 8)  chk("rr_hold_count", 32'(cc_rr), 0);
      if (k == 10) chk("rr_restart_count", 32'(cc_rr), 0);
      if (k == 15) chk("rr_second_c5", 32'(cc_rr), 5);
      if (k == 21) chk("rr_not_done", 32'(dn_rr), 0);
    end
    chk("rr_pass", {29'b0, dn_rr, ps_rr, to_rr}, 32'b110);
    chk("rr_count", 32'(cc_rr), 3);

    // start ignored in RUN, then abort by reset mid-run.
    do_reset();
    d_def = 32'h0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    chk("ign_c2", 32'(cc_def), 2);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_start_in_run", {20'b0, cr_def, cc_def}, 3);
    reset = 1'b1;
    step();
    chk("abort_state", {19'b0, cr_def, dn_def, cc_def}, 32'h1000);
    reset = 1'b0;
    step(); step();
    chk("abort_idle_hold", {19'b0, cr_def, dn_def, cc_def}, 32'h1000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
